// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is consumed CHUNK bits
// per clock, LSB chunk first, through a CHUNK-long ripple of full-add or
// full-subtract cells. The carry/borrow is registered between beats, so the
// datapath area scales with CHUNK rather than WIDTH.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operands and mode are valid
//   start_ready  block can accept a new operation (registered-state decode)
//   mode         0 = add, 1 = subtract
//   a, b         operands (a is minuend, b is subtrahend for subtract)
//   cin          carry-in (add) or borrow-in (subtract)
//   res_valid    result/cout/ovf are valid (registered-state decode)
//   res_ready    consumer accepts the result
//   result       a+b+cin or a-b-cin, modulo 2^WIDTH
//   cout         carry-out (add) or borrow-out (subtract)
//   ovf          two's-complement overflow
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start_valid; start_ready=1
// RUN     | one CHUNK-bit beat per cycle, NBEATS beats in total
// DONE    | result held with res_valid=1 until res_ready
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NBEATS = WIDTH / CHUNK;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("serial_add_sub: CHUNK must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry_q;
    logic             mode_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [CNT_W-1:0] beat_q;

    logic             accept;
    logic             run_beat;
    logic             last_beat;

    logic [CHUNK-1:0] chunk_sum;
    logic             chain_out;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        run_beat  = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_beat = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    last_beat = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from start_valid/res_ready to either of them.
    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // CHUNK-long ripple of full-add / full-subtract cells
    // ------------------------------------------------------------------
    always_comb begin : p_chain
        logic c;
        logic ai;
        logic bi;
        c         = carry_q;
        chunk_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ai           = a_sh[i];
            bi           = b_sh[i];
            chunk_sum[i] = ai ^ bi ^ c;
            if (mode_q) begin
                // borrow out of a - b - c
                c = (~ai & bi) | (~(ai ^ bi) & c);
            end else begin
                c = (ai & bi) | (c & (ai ^ bi));
            end
        end
        chain_out = c;
    end

    // Operands shift right by CHUNK each beat; result bits enter at the MSB
    // end so that after NBEATS beats the first chunk has reached the LSBs.
    generate
        if (CHUNK == WIDTH) begin : g_single_beat
            assign a_next   = '0;
            assign b_next   = '0;
            assign res_next = chunk_sum;
        end else begin : g_multi_beat
            assign a_next   = {{CHUNK{1'b0}}, a_sh[WIDTH-1:CHUNK]};
            assign b_next   = {{CHUNK{1'b0}}, b_sh[WIDTH-1:CHUNK]};
            assign res_next = {chunk_sum, res_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Operand sign bits are kept aside because the shift registers lose them.
    always_comb begin
        if (mode_q) begin
            ovf_next = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end else begin
            ovf_next = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            beat_q  <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            res_sh  <= '0;
            // Loading cin here makes carry_q the chain input on beat 0, so
            // every beat reads the same register.
            carry_q <= cin;
            mode_q  <= mode;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            beat_q  <= '0;
        end else if (run_beat) begin
            a_sh    <= a_next;
            b_sh    <= b_next;
            res_sh  <= res_next;
            carry_q <= chain_out;
            if (last_beat) begin
                result <= res_next;
                cout   <= chain_out;
                ovf    <= ovf_next;
            end else begin
                beat_q <= beat_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//
// Nine instances of serial_add_sub covering every legal CHUNK for WIDTH=8 and
// WIDTH=16. Directed scenarios run on single instances; the random scenario
// drives all instances concurrently and compares against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    localparam int NINST = 9;

    function automatic int width_of(int k);
        return (k < 4) ? 8 : 16;
    endfunction

    function automatic int chunk_of(int k);
        case (k)
            0, 4:    return 1;
            1, 5:    return 2;
            2, 6:    return 4;
            3, 7:    return 8;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;

    logic [NINST-1:0]       sv;
    logic [NINST-1:0]       rr;
    logic [NINST-1:0]       mode_arr;
    logic [NINST-1:0]       cin_arr;
    logic [NINST-1:0][15:0] a_arr;
    logic [NINST-1:0][15:0] b_arr;
    logic [NINST-1:0]       srdy;
    logic [NINST-1:0]       rval;
    logic [NINST-1:0]       cout_arr;
    logic [NINST-1:0]       ovf_arr;
    logic [NINST-1:0][15:0] res_arr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int W = width_of(g);
        localparam int C = chunk_of(g);
        logic [W-1:0] r;
        serial_add_sub #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_valid (sv[g]),
            .start_ready (srdy[g]),
            .mode        (mode_arr[g]),
            .a           (a_arr[g][W-1:0]),
            .b           (b_arr[g][W-1:0]),
            .cin         (cin_arr[g]),
            .res_valid   (rval[g]),
            .res_ready   (rr[g]),
            .result      (r),
            .cout        (cout_arr[g]),
            .ovf         (ovf_arr[g])
        );
        assign res_arr[g] = 16'(r);
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic void ref_model(input int w, input logic m,
                                      input logic [15:0] av, input logic [15:0] bv,
                                      input logic ci, output logic [15:0] r,
                                      output logic co, output logic ov);
        longint mask;
        longint x;
        logic am, bm, rm;
        mask = (longint'(1) << w) - 1;
        if (!m) begin
            x  = longint'(av) + longint'(bv) + longint'(ci);
            co = ((x >> w) & 1) != 0;
        end else begin
            x  = longint'(av) - longint'(bv) - longint'(ci);
            co = longint'(av) < (longint'(bv) + longint'(ci));
        end
        r  = 16'(x & mask);
        am = av[w-1];
        bm = bv[w-1];
        rm = r[w-1];
        ov = m ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    endfunction

    // One complete transaction on instance k; starts and ends at a negedge.
    task automatic run_op(input int k, input logic m, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input logic [15:0] er, input logic ec, input logic eo,
                          input int elat, input int pre, input int post,
                          input string tag);
        int t;
        int lat;
        repeat (pre) @(negedge clk);
        t = 0;
        while (!srdy[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (srdy[k] !== 1'b1) $display("FAIL %s k=%0d start_ready got %b want 1", tag, k, srdy[k]);
        else n_pass++;
        sv[k] = 1'b1; a_arr[k] = av; b_arr[k] = bv; mode_arr[k] = m; cin_arr[k] = ci;
        @(posedge clk);
        #1;
        sv[k] = 1'b0;
        a_arr[k] = 16'($urandom); b_arr[k] = 16'($urandom);
        mode_arr[k] = 1'($urandom); cin_arr[k] = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rval[k] && lat < 200);
        n_checks++;
        if (lat != elat || rval[k] !== 1'b1)
            $display("FAIL %s k=%0d latency got %0d (valid %b) want %0d", tag, k, lat, rval[k], elat);
        else n_pass++;
        n_checks++;
        if (res_arr[k] !== er || cout_arr[k] !== ec || ovf_arr[k] !== eo)
            $display("FAIL %s k=%0d result/cout/ovf got %h/%b/%b want %h/%b/%b",
                     tag, k, res_arr[k], cout_arr[k], ovf_arr[k], er, ec, eo);
        else n_pass++;
        for (int i = 0; i < post; i++) begin
            sv[k] = 1'($urandom);
            a_arr[k] = 16'($urandom); b_arr[k] = 16'($urandom);
            @(negedge clk);
            n_checks++;
            if (res_arr[k] !== er || cout_arr[k] !== ec || ovf_arr[k] !== eo ||
                rval[k] !== 1'b1 || srdy[k] !== 1'b0)
                $display("FAIL %s_hold k=%0d got %h/%b/%b v=%b r=%b want %h/%b/%b v=1 r=0",
                         tag, k, res_arr[k], cout_arr[k], ovf_arr[k], rval[k], srdy[k], er, ec, eo);
            else n_pass++;
        end
        rr[k] = 1'b1;
        sv[k] = 1'b0;
        @(posedge clk);
        #1;
        rr[k] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rval[k] !== 1'b0 || srdy[k] !== 1'b1 || res_arr[k] !== er || cout_arr[k] !== ec || ovf_arr[k] !== eo)
            $display("FAIL %s_pop k=%0d valid=%b ready=%b res=%h want valid=0 ready=1 res=%h",
                     tag, k, rval[k], srdy[k], res_arr[k], er);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NINST; k++) begin
            n_checks++;
            if (srdy[k] !== 1'b1 || rval[k] !== 1'b0 || res_arr[k] !== 16'h0 ||
                cout_arr[k] !== 1'b0 || ovf_arr[k] !== 1'b0)
                $display("FAIL reset k=%0d ready=%b valid=%b res=%h cout=%b ovf=%b want 1 0 0000 0 0",
                         k, srdy[k], rval[k], res_arr[k], cout_arr[k], ovf_arr[k]);
            else n_pass++;
        end
    endtask

    task automatic test_add_chunk1();
        run_op(0, 1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 8, 0, 0, "add_c1");
    endtask

    task automatic test_sub_chunk2();
        run_op(1, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0, 4, 0, 0, "sub_c2");
    endtask

    task automatic test_sub_chunk4();
        run_op(2, 1'b1, 16'h0080, 16'h0001, 1'b1, 16'h007E, 1'b0, 1'b1, 2, 0, 0, "sub_c4");
    endtask

    task automatic test_add_chunk8();
        run_op(3, 1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0, 1, 0, 0, "add_c8");
    endtask

    task automatic test_backpressure();
        int bad;
        run_op(0, 1'b0, 16'h0021, 16'h0013, 1'b0, 16'h0034, 1'b0, 1'b0, 8, 0, 5, "bp");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rval[0] !== 1'b0 || srdy[0] !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_no_second_op bad_cycles got %0d want 0", bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t_acc[$];
        int cyc;
        int t;
        a_arr[0] = 16'h0003; b_arr[0] = 16'h0004; mode_arr[0] = 1'b0; cin_arr[0] = 1'b0;
        rr[0] = 1'b1;
        sv[0] = 1'b1;
        cyc = 0;
        while (t_acc.size() < 3 && cyc < 60) begin
            if (srdy[0]) t_acc.push_back(cyc);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        sv[0] = 1'b0;
        n_checks++;
        if (t_acc.size() != 3) $display("FAIL b2b_accepts got %0d want 3", t_acc.size());
        else n_pass++;
        if (t_acc.size() == 3) begin
            n_checks++;
            if (t_acc[1] - t_acc[0] != 10 || t_acc[2] - t_acc[1] != 10)
                $display("FAIL b2b_period got %0d,%0d want 10,10", t_acc[1] - t_acc[0], t_acc[2] - t_acc[1]);
            else n_pass++;
        end
        n_checks++;
        if (res_arr[0] !== 16'h0007 || cout_arr[0] !== 1'b0 || ovf_arr[0] !== 1'b0)
            $display("FAIL b2b_result got %h/%b/%b want 0007/0/0", res_arr[0], cout_arr[0], ovf_arr[0]);
        else n_pass++;
        t = 0;
        while (!srdy[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        rr[0] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int bad;
        a_arr[0] = 16'h0055; b_arr[0] = 16'h000F; mode_arr[0] = 1'b0; cin_arr[0] = 1'b0;
        sv[0] = 1'b1;
        @(posedge clk);
        #1;
        sv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (srdy[0] !== 1'b1 || rval[0] !== 1'b0 || res_arr[0] !== 16'h0 ||
            cout_arr[0] !== 1'b0 || ovf_arr[0] !== 1'b0)
            $display("FAIL abort_reset ready=%b valid=%b res=%h cout=%b ovf=%b want 1 0 0000 0 0",
                     srdy[0], rval[0], res_arr[0], cout_arr[0], ovf_arr[0]);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rval[0] !== 1'b0 || srdy[0] !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_result bad_cycles got %0d want 0", bad);
        else n_pass++;
        run_op(0, 1'b0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 8, 0, 0, "abort_follow");
    endtask

    task automatic rand_inst(input int k, input int n);
        int w;
        logic [15:0] mask, av, bv, er;
        logic m, ci, ec, eo;
        w = width_of(k);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        for (int i = 0; i < n; i++) begin
            av = 16'($urandom) & mask;
            bv = 16'($urandom) & mask;
            m  = 1'($urandom);
            ci = 1'($urandom);
            ref_model(w, m, av, bv, ci, er, ec, eo);
            run_op(k, m, av, bv, ci, er, ec, eo, w / chunk_of(k),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rand");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < NINST; k++) begin
            automatic int kk = k;
            fork
                rand_inst(kk, 1112);
            join_none
        end
        wait fork;
    endtask

    initial begin
        rst_n    = 1'b0;
        sv       = '0;
        rr       = '0;
        mode_arr = '0;
        cin_arr  = '0;
        a_arr    = '0;
        b_arr    = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add_chunk1();
        test_sub_chunk2();
        test_sub_chunk4();
        test_add_chunk8();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
